logic_unit_pipe: RTL and testbench
==================================

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with clock port clk and reset port reset_n.
REQ-002 Parameter WIDTH, default 8, SHALL set the operand and result width in bits (WIDTH >= 1).
REQ-003 Parameter COUNT_W, default 8, SHALL set the width of the completed-operation counter.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset_n  input  1  synchronous active-low reset.
REQ-006 in_valid  input  1  upstream operand set valid.
REQ-007 in_ready  output  1  block can accept an operand set this cycle.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 op  input  3  operation select.
REQ-011 acc_en  input  1  use the accumulator in place of operand A.
REQ-012 acc_clr  input  1  clear the accumulator.
REQ-013 out_valid  output  1  result valid.
REQ-014 out_ready  input  1  downstream accepts the result.
REQ-015 result  output  WIDTH  registered result.
REQ-016 zero  output  1  registered result equals 0.
REQ-017 op_count  output  COUNT_W  number of results delivered, modulo 2^COUNT_W.

Function
REQ-018 The op encoding SHALL be: 000 AND; 001 NAND; 010 OR; 011 NOR; 100 XOR; 101 XNOR; 110 NOT A; 111 PASS A. All operations are bitwise over WIDTH bits.
REQ-019 An operand set SHALL be accepted only in a cycle where in_valid=1 and in_ready=1.
REQ-020 in_ready SHALL equal (!out_valid || out_ready), which gives a single output stage with no bubble under streaming.
REQ-021 The output stage SHALL be a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-022 EMPTY SHALL go to FULL on accept.
REQ-023 FULL SHALL go to EMPTY when out_ready=1 and no new accept occurs.
REQ-024 FULL SHALL stay FULL when out_ready=1 and a new accept occurs, with result replaced.
REQ-025 FULL SHALL stay FULL, holding result and zero, while out_ready=0.
REQ-026 Latency SHALL be one cycle: result, zero and out_valid are updated on the clock edge at which the operand set is accepted.
REQ-027 The effective operand A SHALL be the accumulator when acc_en=1, and a otherwise.
REQ-028 On every accept, the accumulator SHALL load the new result, whether or not acc_en is set.
REQ-029 When acc_clr=1 and there is no accept, the accumulator SHALL load 0 at the next edge.
REQ-030 When acc_clr=1 and an accept occurs in the same cycle, the effective A SHALL be 0 if acc_en=1, and the accumulator SHALL load the new result (result has priority over the clear).
REQ-031 op_count SHALL increment by 1 on each cycle with out_valid=1 and out_ready=1, and SHALL wrap from 2^COUNT_W-1 to 0.
REQ-032 Inputs SHALL be ignored when there is no accept; a, b and op need not be held stable.

Reset
REQ-033 When reset_n=0 at a rising edge, the block SHALL set out_valid=0, result=0, zero=0, the accumulator to 0, op_count=0 and the FSM to EMPTY.
REQ-034 in_ready SHALL read 1 in the first cycle after reset is released.
REQ-035 Reset asserted while FULL SHALL discard the pending result without a handshake and without incrementing op_count.

Structure
REQ-036 The op encoding constants (OP_AND through OP_PASS) and the EMPTY/FULL state encoding SHALL live in the shared package logic_unit_pkg.
REQ-037 The combinational operation SHALL be the sub-module logic_op (inputs a, b, op; output y), instantiated once; the FSM, accumulator and counter SHALL reside in logic_unit_pipe.

Verification
REQ-038 Reset: hold reset_n=0 for 2 cycles, then release -> out_valid=0, result=0, op_count=0, in_ready=1.
REQ-039 Basic ops (WIDTH=8, out_ready=1): a=F0, b=3C, op=000 -> result=30; op=001 -> CF; op=100 -> CC; op=110 -> 0F; each is valid one cycle after accept.
REQ-040 Backpressure: with FULL and out_ready=0 for 3 cycles -> in_ready=0, result held, a new in_valid is not accepted; after out_ready=1 -> op_count+1 and the next set is accepted in the same cycle.
REQ-041 Accumulate: pulse acc_clr, then acc_en=1, op=100, b=01, 02, 04 in consecutive cycles -> result=01, 03, 07; then op=000 with b=05 and acc_en=1 -> result=05, zero=0; then b=00 -> result=00, zero=1.
REQ-042 Counter wrap: COUNT_W=4, 17 back-to-back transfers -> op_count=1.
REQ-043 Reset mid-operation: FULL with out_ready=0, then reset_n=0 for one edge -> out_valid=0, op_count unchanged from 0; accumulator reads 0 on the next acc_en XOR with b=00.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared encodings for the bitwise logic pipeline: operation select codes
// and the output-stage state encoding.
package logic_unit_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_NAND = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_NOTA = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/logic_op.sv
// Purely combinational bitwise operator selected by a 3-bit op code.
module logic_op
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y
);

    // Select one bitwise function of a and b.
    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_NAND: y = ~(a & b);
            OP_OR:   y = a | b;
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_NOTA: y = ~a;
            OP_PASS: y = a;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Single-stage valid/ready pipeline around logic_op, with an accumulator
// that can replace operand A and a counter of delivered results.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | no result held, out_valid=0, always ready
// ST_FULL  | result held, out_valid=1, ready only if out_ready
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2:0]         op,
    input  logic               acc_en,
    input  logic               acc_clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic [COUNT_W-1:0] op_count
);

    state_t               r_state;
    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_result;
    logic                 r_zero;
    logic [WIDTH-1:0]     r_acc;
    logic [COUNT_W-1:0]   r_count;

    logic                 w_accept;
    logic                 w_deliver;
    logic [WIDTH-1:0]     w_op_a;
    logic [WIDTH-1:0]     w_y;
    logic                 w_zero;

    assign in_ready  = !r_out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_deliver = r_out_valid && out_ready;

    // A clear coinciding with an accumulate makes the accumulator read as zero.
    assign w_op_a = acc_en ? (acc_clr ? '0 : r_acc) : a;
    assign w_zero = (w_y == '0);

    logic_op #(.WIDTH(WIDTH)) u_logic_op (
        .a  (w_op_a),
        .b  (b),
        .op (op),
        .y  (w_y)
    );

    // Output-stage FSM with registered result, zero flag and valid.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_state     <= ST_FULL;
                        r_out_valid <= 1'b1;
                        r_result    <= w_y;
                        r_zero      <= w_zero;
                    end
                end
                ST_FULL: begin
                    if (w_accept) begin
                        r_result <= w_y;
                        r_zero   <= w_zero;
                    end else if (out_ready) begin
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Accumulator: a new result wins over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_acc <= '0;
        end else if (w_accept) begin
            r_acc <= w_y;
        end else if (acc_clr) begin
            r_acc <= '0;
        end
    end

    // Count delivered results, wrapping naturally at the counter width.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (w_deliver) begin
            r_count <= r_count + COUNT_W'(1);
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign op_count  = r_count;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: table-driven basic ops, directed
// handshake/accumulator/reset sequences and random traffic against a
// cycle-level reference model. A second instance with a 4-bit counter shares
// the stimulus to exercise counter wrap.
module tb_logic_unit_pipe;

    logic       clk;
    logic       reset_n;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       acc_en;
    logic       acc_clr;
    logic       out_ready;

    logic       in_ready, out_valid, zero;
    logic [7:0] result;
    logic [7:0] op_count;

    logic       in_ready4, out_valid4, zero4;
    logic [7:0] result4;
    logic [3:0] op_count4;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit       m_valid;
    bit [7:0] m_res;
    bit       m_zero;
    bit [7:0] m_acc;
    int       m_cnt;

    logic_unit_pipe #(.WIDTH(8), .COUNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .op_count(op_count)
    );

    logic_unit_pipe #(.WIDTH(8), .COUNT_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready4),
        .a(a), .b(b), .op(op), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid4), .out_ready(out_ready), .result(result4),
        .zero(zero4), .op_count(op_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic bit [7:0] ref_op(input bit [2:0] o, input bit [7:0] x, input bit [7:0] y);
        case (o)
            3'd0: return x & y;
            3'd1: return ~(x & y);
            3'd2: return x | y;
            3'd3: return ~(x | y);
            3'd4: return x ^ y;
            3'd5: return ~(x ^ y);
            3'd6: return ~x;
            default: return x;
        endcase
    endfunction

    task automatic check_outputs();
        chk("out_valid", out_valid, m_valid);
        chk("op_count", op_count, m_cnt % 256);
        chk("op_count4", op_count4, m_cnt % 16);
        if (m_valid) begin
            chk("result", result, m_res);
            chk("zero", zero, m_zero);
        end
    endtask

    // One clock: drive inputs, check in_ready, advance model, check outputs.
    task automatic cycle(input bit v, input bit [7:0] ia, input bit [7:0] ib, input bit [2:0] iop,
                         input bit en, input bit clr, input bit ordy);
        bit rdy, acc_ok;
        bit [7:0] ea, y;
        in_valid = v; a = ia; b = ib; op = iop; acc_en = en; acc_clr = clr; out_ready = ordy;
        #1;
        rdy = !m_valid || ordy;
        chk("in_ready", in_ready, rdy);
        chk("in_ready4", in_ready4, rdy);
        acc_ok = v && rdy;
        if (m_valid && ordy) m_cnt++;
        if (acc_ok) begin
            ea = en ? (clr ? 8'h00 : m_acc) : ia;
            y  = ref_op(iop, ea, ib);
            m_res = y; m_zero = (y == 8'h00); m_valid = 1'b1; m_acc = y;
        end else begin
            if (m_valid && ordy) m_valid = 1'b0;
            if (clr) m_acc = 8'h00;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        in_valid = 1'b0; acc_en = 1'b0; acc_clr = 1'b0; out_ready = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        m_valid = 1'b0; m_res = 8'h00; m_zero = 1'b0; m_acc = 8'h00; m_cnt = 0;
        reset_n = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", result, 8'h00);
        chk("rst_zero", zero, 1'b0);
        chk("rst_op_count", op_count, 8'h00);
        chk("rst_in_ready", in_ready, 1'b1);
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{3'b000, 8'hF0, 8'h3C, 8'h30};
        vecs[1] = '{3'b001, 8'hF0, 8'h3C, 8'hCF};
        vecs[2] = '{3'b100, 8'hF0, 8'h3C, 8'hCC};
        vecs[3] = '{3'b110, 8'hF0, 8'h3C, 8'h0F};
        vecs[4] = '{3'b010, 8'hF0, 8'h3C, 8'hFC};
        vecs[5] = '{3'b011, 8'hF0, 8'h3C, 8'h03};
        vecs[6] = '{3'b101, 8'hF0, 8'h3C, 8'h33};
        vecs[7] = '{3'b111, 8'hF0, 8'h3C, 8'hF0};

        a = 8'h00; b = 8'h00; op = 3'b000;
        @(posedge clk);
        do_reset(2);

        // basic ops, one cycle latency, streaming with out_ready=1
        for (int i = 0; i < 8; i++) begin
            cycle(1, vecs[i].a, vecs[i].b, vecs[i].op, 0, 0, 1);
            chk($sformatf("vec%0d_result", i), result, vecs[i].exp);
            chk($sformatf("vec%0d_valid", i), out_valid, 1'b1);
        end
        cycle(0, 8'h00, 8'h00, 3'b000, 0, 0, 1);
        chk("drain_valid", out_valid, 1'b0);
        chk("drain_count", op_count, 8'd8);

        // backpressure: held result, no accept while stalled
        cycle(1, 8'hAA, 8'h0F, 3'b000, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 8'h55 + 8'(i), 8'hFF, 3'b111, 0, 0, 0);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_result_held", result, 8'h0A);
        end
        cycle(1, 8'h12, 8'h34, 3'b010, 0, 0, 1);
        chk("bp_release_count", op_count, 8'd9);
        chk("bp_new_result", result, 8'h36);
        cycle(0, 8'h00, 8'h00, 3'b000, 0, 0, 1);

        // accumulate sequence
        cycle(0, 8'h00, 8'h00, 3'b000, 0, 1, 1);
        cycle(1, 8'hEE, 8'h01, 3'b100, 1, 0, 1);
        chk("acc_01", result, 8'h01);
        cycle(1, 8'hEE, 8'h02, 3'b100, 1, 0, 1);
        chk("acc_03", result, 8'h03);
        cycle(1, 8'hEE, 8'h04, 3'b100, 1, 0, 1);
        chk("acc_07", result, 8'h07);
        cycle(1, 8'hEE, 8'h05, 3'b000, 1, 0, 1);
        chk("acc_and05", result, 8'h05);
        chk("acc_zero0", zero, 1'b0);
        cycle(1, 8'hEE, 8'h00, 3'b000, 1, 0, 1);
        chk("acc_and00", result, 8'h00);
        chk("acc_zero1", zero, 1'b1);

        // clear coinciding with accumulate: effective A is 0
        cycle(1, 8'h00, 8'hC3, 3'b111, 0, 0, 1);
        cycle(1, 8'hFF, 8'h3C, 3'b010, 1, 1, 1);
        chk("clr_acc_same_cycle", result, 8'h3C);
        cycle(1, 8'hFF, 8'h00, 3'b100, 1, 0, 1);
        chk("clr_acc_loaded_result", result, 8'h3C);

        // counter wrap on the 4-bit instance
        do_reset(1);
        for (int i = 0; i < 17; i++) cycle(1, 8'(i), 8'hFF, 3'b000, 0, 0, 1);
        cycle(0, 8'h00, 8'h00, 3'b000, 0, 0, 1);
        chk("wrap_count4", op_count4, 4'd1);
        chk("wrap_count8", op_count, 8'd17);

        // reset while FULL discards the result
        do_reset(1);
        cycle(1, 8'h5A, 8'hFF, 3'b111, 0, 0, 0);
        chk("pre_rst_valid", out_valid, 1'b1);
        do_reset(1);
        chk("mid_rst_count", op_count, 8'd0);
        cycle(1, 8'hFF, 8'h00, 3'b100, 1, 0, 1);
        chk("mid_rst_acc_zero", result, 8'h00);
        chk("mid_rst_zero_flag", zero, 1'b1);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 3'($urandom),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
